// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared types and sizing helpers for the main FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

  localparam int unsigned C_DEFAULT_QUEUE_SIZE = 3;

  // Number of RAM words addressed by a pointer of the given width.
  function automatic int unsigned fifo_depth(input int unsigned queue_size);
    return 32'd1 << queue_size;
  endfunction

endpackage : fifo_ctrl_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Wrapping RAM address pointer with increment enable.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] r_ptr;

  // Overflow past the top address wraps naturally to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : Push/pop control, occupancy and status flags for the main
//               FIFO RAM. Define FIFO_CTRL_ERR_EN to build the sticky
//               overflow/underflow error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MAIN_QUEUE_SIZE = C_DEFAULT_QUEUE_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [MAIN_QUEUE_SIZE:0]   af_th,
  input  logic [MAIN_QUEUE_SIZE:0]   ae_th,
  output logic                       write,
  output logic                       read,
  output logic [MAIN_QUEUE_SIZE-1:0] wr_ptr,
  output logic [MAIN_QUEUE_SIZE-1:0] rd_ptr,
  output logic [MAIN_QUEUE_SIZE:0]   count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       error
);

  localparam int unsigned DEPTH = fifo_depth(MAIN_QUEUE_SIZE);
  localparam logic [MAIN_QUEUE_SIZE:0] C_DEPTH = (MAIN_QUEUE_SIZE+1)'(DEPTH);
  localparam logic [MAIN_QUEUE_SIZE:0] C_ONE   = (MAIN_QUEUE_SIZE+1)'(1);

  logic                     w_push_ok;
  logic                     w_pop_ok;
  logic [MAIN_QUEUE_SIZE:0] r_count;
  logic [MAIN_QUEUE_SIZE:0] w_count_nxt;
  fifo_state_t              r_state;
  fifo_state_t              w_state_nxt;
  logic                     r_full;
  logic                     r_empty;
  logic                     r_almost_full;
  logic                     r_almost_empty;

  // A push into a full FIFO is fine when the head is popped in the same cycle;
  // the RAM reads the head combinationally before the edge overwrites it.
  assign w_push_ok = push && (!r_full || pop) && !reset;
  assign w_pop_ok  = pop && !r_empty && !reset;

  assign write = w_push_ok;
  assign read  = w_pop_ok;

  fifo_ptr #(
    .WIDTH (MAIN_QUEUE_SIZE)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .WIDTH (MAIN_QUEUE_SIZE)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pop_ok),
    .ptr   (rd_ptr)
  );

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push_ok && !w_pop_ok) begin
          w_state_nxt = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (w_push_ok && !w_pop_ok && (r_count == C_DEPTH - C_ONE)) begin
          w_state_nxt = ST_FULL;
        end else if (w_pop_ok && !w_push_ok && (r_count == C_ONE)) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop_ok && !w_push_ok) begin
          w_state_nxt = ST_PARTIAL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Flags are registered from the next count so they line up with count;
  // thresholds are sampled live every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_full         <= (w_count_nxt == C_DEPTH);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= af_th);
      r_almost_empty <= (w_count_nxt <= ae_th);
    end
  end

  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;

`ifdef FIFO_CTRL_ERR_EN
  logic r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if ((push && r_full && !pop) || (pop && r_empty)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Scoreboard testbench for fifo_ctrl (honours FIFO_CTRL_ERR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  localparam int QS    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [QS:0]   af_th;
  logic [QS:0]   ae_th;
  logic          write;
  logic          read;
  logic [QS-1:0] wr_ptr;
  logic [QS-1:0] rd_ptr;
  logic [QS:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  fifo_ctrl #(
    .MAIN_QUEUE_SIZE (QS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .af_th        (af_th),
    .ae_th        (ae_th),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned wr;
    int unsigned rd;
    int unsigned cnt;
    bit          full;
    bit          empty;
    bit          af;
    bit          ae;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int unsigned m_count;
  int unsigned m_wr;
  int unsigned m_rd;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wr    = 0;
    m_rd    = 0;
    m_err   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " wr_ptr"}, 32'(wr_ptr), 0);
    check({tag, " rd_ptr"}, 32'(rd_ptr), 0);
    check({tag, " count"}, 32'(count), 0);
    check({tag, " empty"}, 32'(empty), 1);
    check({tag, " full"}, 32'(full), 0);
    check({tag, " almost_empty"}, 32'(almost_empty), 1);
    check({tag, " almost_full"}, 32'(almost_full), 0);
    check({tag, " error"}, 32'(error), 0);
    check({tag, " write"}, 32'(write), 0);
    check({tag, " read"}, 32'(read), 0);
  endtask

  // One clock of stimulus: checks the combinational enables, queues the
  // expected post-edge state, then pops and compares it after the edge.
  task automatic step(input bit p, input bit q);
    bit   pok;
    bit   qok;
    exp_t e;
    exp_t x;
    push = p;
    pop  = q;
    #1;
    pok = p && ((m_count != DEPTH) || q);
    qok = q && (m_count != 0);
    check("write", 32'(write), 32'(pok));
    check("read", 32'(read), 32'(qok));
`ifdef FIFO_CTRL_ERR_EN
    if ((p && (m_count == DEPTH) && !q) || (q && (m_count == 0))) m_err = 1'b1;
`endif
    m_wr    = (m_wr + 32'(pok)) % DEPTH;
    m_rd    = (m_rd + 32'(qok)) % DEPTH;
    m_count = m_count + 32'(pok) - 32'(qok);
    e.wr    = m_wr;
    e.rd    = m_rd;
    e.cnt   = m_count;
    e.full  = (m_count == DEPTH);
    e.empty = (m_count == 0);
    e.af    = (m_count >= 32'(af_th));
    e.ae    = (m_count <= 32'(ae_th));
    e.err   = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    x = sb.pop_front();
    check("wr_ptr", 32'(wr_ptr), x.wr);
    check("rd_ptr", 32'(rd_ptr), x.rd);
    check("count", 32'(count), x.cnt);
    check("full", 32'(full), 32'(x.full));
    check("empty", 32'(empty), 32'(x.empty));
    check("almost_full", 32'(almost_full), 32'(x.af));
    check("almost_empty", 32'(almost_empty), 32'(x.ae));
    check("error", 32'(error), 32'(x.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    push  = 1'b1;
    pop   = 1'b1;
    af_th = 4'd6;
    ae_th = 4'd1;
    model_reset();
    #2;
    check_reset_values("por");
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b0;
    #1;

    // Fill: wr_ptr walks 0..7 and wraps, flags follow the count.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
    check("fill state", {28'd0, full, almost_full, almost_empty, empty}, 32'b1100);

    // Overflow attempt is rejected.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Simultaneous push/pop while full.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Drain, then underflow attempt.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Push+pop while empty: only the push lands.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // A zero almost-full threshold holds the flag high even when empty.
    af_th = 4'd0;
    step(1'b0, 1'b0);
    af_th = 4'd6;

    // Randomised traffic with occasional threshold changes.
    for (int i = 0; i < 80; i++) begin
      if ((i % 16) == 0) begin
        af_th = 4'($urandom_range(0, DEPTH));
        ae_th = 4'($urandom_range(0, DEPTH));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Bring the FIFO to count=5, then reset mid-cycle.
    af_th = 4'd6;
    ae_th = 4'd1;
    while (m_count > 0) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("pre-reset count", 32'(count), 5);
    push = 1'b1;
    pop  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    push = 1'b0;
    pop  = 1'b0;
    #1;
    reset = 1'b0;
    #1;

    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_ctrl
`default_nettype wire

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control block for the main FIFO built on `RAM_memory`. It turns requester `push`/`pop` strobes into the RAM `write`/`read` enables and the `wr_ptr`/`rd_ptr` addresses. It keeps the occupancy count and status flags (full, empty, almost-full, almost-empty, error). It sits between the upstream/downstream logic and the RAM; data never passes through it.

## Interface
- `MAIN_QUEUE_SIZE`, default 3: pointer width; FIFO depth is DEPTH = 2**MAIN_QUEUE_SIZE (8).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `push`  in  1: requester wants to store one word this cycle.
- `pop`  in  1: requester consumes the head word (RAM `data_out`) this cycle.
- `af_th`  in  MAIN_QUEUE_SIZE+1: almost-full threshold.
- `ae_th`  in  MAIN_QUEUE_SIZE+1: almost-empty threshold.
- `write`  out  1: RAM write enable.
- `read`  out  1: RAM read enable.
- `wr_ptr`  out  MAIN_QUEUE_SIZE: RAM write address.
- `rd_ptr`  out  MAIN_QUEUE_SIZE: RAM read address.
- `count`  out  MAIN_QUEUE_SIZE+1: occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each: status flags.
- `error`  out  1: sticky overflow/underflow flag (see Configuration).

## Operation
- State machine with three states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
- Accept rules:
  - push_ok = push && (!full || pop).
  - pop_ok = pop && !empty.
  - Push and pop while full: both are accepted. The head word is read combinationally before the edge overwrites it.
  - Push and pop while empty: the push is accepted and the pop is rejected.
- `write` = push_ok and `read` = pop_ok. Both are purely combinational.
- On each edge:
  - wr_ptr += push_ok and rd_ptr += pop_ok, with natural modulo-DEPTH wrap (7→0).
  - count += push_ok − pop_ok.
- State transitions:
  - EMPTY→PARTIAL on a lone push.
  - PARTIAL→FULL on a lone push at count=DEPTH−1.
  - PARTIAL→EMPTY on a lone pop at count=1.
  - FULL→PARTIAL on a lone pop.
  - Simultaneous push_ok and pop_ok: state holds.
- Flags are registered and computed from the next count:
  - full = (count==DEPTH).
  - empty = (count==0).
  - almost_full = (count >= af_th).
  - almost_empty = (count <= ae_th).
- Thresholds are compared live, with no latching. af_th=0 forces almost_full to 1 permanently.
- Rejected operations change no pointer or count.

## Timing
- Reset values (asynchronous, immediate): wr_ptr=0, rd_ptr=0, count=0, state EMPTY, empty=1, full=0, almost_empty=1, almost_full=0, error=0.
- While reset is high, `write`=0 and `read`=0 regardless of push/pop.
- Latency:
  - push→RAM write: same edge.
  - pop→head word valid: head is already valid on `data_out` while empty=0; rd_ptr advances at the edge.
  - Flags and count are updated one edge after the accepted operation.
- Reset asserted mid-operation: all state returns to its reset value. RAM contents are not cleared but are treated as invalid.

## Configuration
- `FIFO_CTRL_ERR_EN` defined:
  - `error` sets on any cycle with push && full && !pop (overflow) or pop && empty (underflow).
  - It stays set until reset.
- Not defined: `error` is tied to 0 and no error logic is synthesised. Rejection of the offending operation is identical in both builds.

## Structure
- Package `fifo_ctrl_pkg`: state enum (ST_EMPTY, ST_PARTIAL, ST_FULL) and a DEPTH-from-MAIN_QUEUE_SIZE helper constant.
- One sub-module, `fifo_ptr`: a MAIN_QUEUE_SIZE-bit wrapping pointer register with inc enable and async reset. It is instantiated twice, for wr_ptr and rd_ptr.
- Top module: accept logic, count, FSM, flags, error.

## Test plan
- Reset, then 8 pushes, no pops (af_th=6, ae_th=1):
  - wr_ptr 0..7 then wraps to 0.
  - almost_full rises after the 6th push; full=1 and count=8 after the 8th.
  - almost_empty falls after the 2nd push.
- Full FIFO, then a 9th push: write=0 and the pointers are unchanged. With the macro, error=1 and sticks; without it, error=0.
- Full FIFO, push+pop together: write=1, read=1, count stays 8, both pointers advance by 1, state stays FULL.
- Empty FIFO, push+pop together: write=1, read=0, count=1, empty=0. With the macro, error=1 from the underflow.
- Drain a full FIFO with 8 pops: rd_ptr wraps 7→0, empty=1 after the 8th pop, and a further pop gives read=0.
- Assert reset with count=5: all outputs return to their reset values immediately, without waiting for a clock edge.
